// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the unified memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, requester IDs, latency counter width and
// a helper that turns a memory latency into the counter load value.
package mem_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    // Requester identities as carried on grant_id.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    // Latency counter width; covers MEM_LAT up to 15.
    localparam int CNT_W = 4;

    // BUSY runs from cnt = MEM_LAT-1 down to 0, so MEM_LAT = 1 loads 0.
    function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Purpose: combinational winner selection between the two requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the FSM only samples the pick while IDLE.
//
// Ports: req0/req1 (requests), last_grant (port that completed last),
//        grant_valid (any request), grant_id (winning port).
// Build option ARB_ROUND_ROBIN_EN: defined -> simultaneous requests go to
// the port not granted last; undefined -> port 0 always wins a tie.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifndef ARB_ROUND_ROBIN_EN
    // Pointer is still wired in fixed-priority builds but has no effect.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ_CORE;
`ifdef ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            // Alternate on a tie: whoever did not go last goes now.
            grant_id = (last_grant == REQ_CORE) ? REQ_DMA : REQ_CORE;
        end else if (req1) begin
            grant_id = REQ_DMA;
        end
`else
        if (!req0 && req1) begin
            grant_id = REQ_DMA;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between core (port 0) and loader/DMA (port 1).
// Latency: req at edge 0 -> BUSY cycles 1..MEM_LAT -> done pulse in MEM_LAT+1.
// Backpressure: requester holds req/we/addr/wdata until its done pulse.
//
// Ports: clk, Reset (sync, active high); per port reqX/weX/addrX/wdataX in,
//        doneX/rdataX out; memory side mem_en/mem_we/mem_addr/mem_wdata out,
//        mem_rdata in; status grant_id/busy.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see arb_pick).
// MEM_LAT must be in 1..15 to fit the latency counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_id,
    output logic          busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_to_cnt(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             op_we;       // captured direction of the access in flight
    logic             last_grant;  // port that most recently completed

    logic             pick_vld;
    logic             pick_id;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (pick_vld),
        .grant_id    (pick_id)
    );

    // Request fields of whichever port the picker selects this cycle.
    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (pick_id == REQ_DMA) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_we      <= 1'b0;
            last_grant <= REQ_DMA;   // so port 0 takes the first tie
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= REQ_CORE;
            busy       <= 1'b0;
        end else begin
            // Done is a single-cycle pulse; only the BUSY exit raises it.
            done0 <= 1'b0;
            done1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        // Inputs are captured once here; later changes are ignored.
                        state     <= BUSY;
                        grant_id  <= pick_id;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        op_we     <= sel_we;
                        cnt       <= LAT_LOAD;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        // With a one-cycle latency the first BUSY cycle is also
                        // the last, so the strobe must be raised right away.
                        mem_we    <= sel_we && (LAT_LOAD == '0);
                    end
                end

                BUSY: begin
                    if (cnt == '0) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (grant_id == REQ_DMA) begin
                            done1 <= 1'b1;
                            if (!op_we) begin
                                rdata1 <= mem_rdata;
                            end
                        end else begin
                            done0 <= 1'b1;
                            if (!op_we) begin
                                rdata0 <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt    <= cnt - CNT_ONE;
                        // Strobe exactly once, during the cnt == 0 cycle.
                        mem_we <= op_we && (cnt == CNT_ONE);
                    end
                end

                DONE: begin
                    // One bubble cycle back in IDLE before the next grant.
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                end

                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    int total = 0;
    int bad   = 0;

    logic clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance (MEM_LAT = 2)
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        done0, done1, mem_en, mem_we, grant_id, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    // Second instance (MEM_LAT = 1), read-only pattern memory
    logic        l_req0 = 0;
    logic [31:0] l_addr0 = 0;
    logic        l_done0, l_done1, l_mem_en, l_mem_we, l_grant_id, l_busy;
    logic [31:0] l_rdata0, l_rdata1, l_mem_addr, l_mem_wdata, l_mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .Reset(Reset),
        .req0(l_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(l_addr0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
        .done0(l_done0), .done1(l_done1), .rdata0(l_rdata0), .rdata1(l_rdata1),
        .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr),
        .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata),
        .grant_id(l_grant_id), .busy(l_busy)
    );

    // Memory environment: 128 words, untouched words read an initial pattern.
    function automatic logic [31:0] init_pat(input int idx);
        if (idx == 4) return 32'hDEAD_BEEF;
        return (32'(idx) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, ~a[15:0]};
    endfunction

    logic [31:0] mem [0:127];
    bit          written [0:127];
    int          we_cnt = 0;
    int          done_seen = 0;

    assign mem_rdata   = mem_en ? (written[mem_addr[8:2]] ? mem[mem_addr[8:2]]
                                                          : init_pat(int'(mem_addr[8:2])))
                                : 32'hBAD0_BAD0;
    assign l_mem_rdata = l_mem_en ? pat(l_mem_addr) : 32'hBAD1_BAD1;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[8:2]]     <= mem_wdata;
            written[mem_addr[8:2]] <= 1'b1;
            we_cnt++;
        end
        if (done0 || done1) done_seen++;
    end

    // Transaction-level reference: memory image plus expected held rdata.
    logic [31:0] model [0:127];
    logic [31:0] exp_rd [0:1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!Reset) begin
            chk("done_exclusive", 32'(done0 & done1), 32'h0);
            chk("we_outside_busy", 32'(mem_we & ~(busy & mem_en)), 32'h0);
            chk("l1_no_write", 32'(l_mem_we), 32'h0);
        end
    end

    task automatic set_port(input int port, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else           begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // One isolated access on one port; a2 is presented from cycle 1 onward.
    task automatic access(input int port, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] a2);
        int wc = we_cnt;
        int dn = 0;
        @(negedge clk);
        set_port(port, 1'b1, w, a, d);
        for (int n = 1; n <= LAT + 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (port == 0) addr0 = a2; else addr1 = a2;
            end
            if (n <= LAT) begin
                chk("mem_en_busy", 32'(mem_en), 32'h1);
                chk("mem_addr_held", mem_addr, a);
                chk("grant_id", 32'(grant_id), 32'(port));
                chk("busy", 32'(busy), 32'h1);
            end
            if (n == LAT) begin
                chk("mem_we_last", 32'(mem_we), 32'(w));
                if (w) chk("mem_wdata", mem_wdata, d);
            end
            if (n < LAT) chk("mem_we_early", 32'(mem_we), 32'h0);
            if (n == LAT + 1) begin
                if (w) model[a[8:2]] = d;
                else   exp_rd[port] = model[a[8:2]];
                chk("done_own", 32'(port == 0 ? done0 : done1), 32'h1);
                chk("done_other", 32'(port == 0 ? done1 : done0), 32'h0);
                chk("mem_en_done", 32'(mem_en), 32'h0);
                chk("rdata0", rdata0, exp_rd[0]);
                chk("rdata1", rdata1, exp_rd[1]);
                set_port(port, 1'b0, 1'b0, a2, 32'h0);
            end
            if (done0 || done1) dn++;
        end
        chk("write_strobes", 32'(we_cnt - wc), 32'(w));
        chk("done_pulses", 32'(dn), 32'h1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},  {30'h0, done1, done0}, 32'h0);
        chk({tag, "_rdata0"}, rdata0, 32'h0);
        chk({tag, "_rdata1"}, rdata1, 32'h0);
        chk({tag, "_mem"},   {28'h0, mem_en, mem_we, grant_id, busy}, 32'h0);
        chk({tag, "_maddr"}, mem_addr, 32'h0);
        chk({tag, "_mwdata"}, mem_wdata, 32'h0);
        chk({tag, "_l1"},    {27'h0, l_done0, l_mem_en, l_busy, l_grant_id, l_done1}, 32'h0);
    endtask

    initial begin
        int order [0:3];
        int when  [0:3];
        int k;
        int wc, ds;
        logic [31:0] la [0:3];
        logic        w;
        logic [31:0] a, d;
        int          p;

        for (int i = 0; i < 128; i++) model[i] = init_pat(i);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        Reset = 1'b0;

        // Single read port 0, single write port 1, address change after grant
        access(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0010);
        chk("first_read_value", rdata0, 32'hDEAD_BEEF);
        access(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0000_0100);
        access(0, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0080);

        // Reset during cycle 1 of a port-0 write
        wc = we_cnt;
        ds = done_seen;
        @(negedge clk);
        set_port(0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        Reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_all_zero("mid_reset");
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("aborted_no_write", 32'(we_cnt - wc), 32'h0);
        chk("aborted_no_done", 32'(done_seen - ds), 32'h0);
        access(1, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0030);

        // Both ports requesting continuously for four accesses
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        k = 0;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(negedge clk);
            if (done0 || done1) begin
                order[k] = done1 ? 1 : 0;
                when[k]  = n;
                k++;
                if (k == 4) begin
                    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
                    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        chk("tie_count", 32'(k), 32'h4);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk("tie_order", 32'(order[i]), 32'(i % 2));
`else
            chk("tie_order", 32'(order[i]), 32'h0);
`endif
            chk("tie_done_cycle", 32'(when[i]), 32'(LAT + 1 + i * (LAT + 2)));
        end
        exp_rd[0] = model[4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_rd[1] = model[8];
`endif
        repeat (3) @(negedge clk);
        chk("tie_rdata0", rdata0, exp_rd[0]);
        chk("tie_rdata1", rdata1, exp_rd[1]);

        // MEM_LAT = 1, back-to-back reads with req held
        la[0] = 32'h0000_0104; la[1] = 32'h0000_0208;
        la[2] = 32'h0000_030C; la[3] = 32'h0;
        @(negedge clk);
        l_req0  = 1'b1;
        l_addr0 = la[0];
        k = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk("l1_done1", 32'(l_done1), 32'h0);
            if (l_done0 && k < 3) begin
                chk("l1_done_cycle", 32'(n), 32'(2 + 3 * k));
                chk("l1_rdata", l_rdata0, pat(la[k]));
                k++;
                l_addr0 = la[k];
                if (k == 3) l_req0 = 1'b0;
            end
        end
        chk("l1_count", 32'(k), 32'h3);

        // Randomized single-port accesses against the memory image
        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
            d = $urandom;
            access(p, w, a, d, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle ARM core between two requesters: port 0 (core FSM fetch/load/store path) and port 1 (program loader / debug DMA).
- Sits between the requesters and the memory macro; sequences each access over a fixed memory latency and returns a one-cycle done pulse with read data.
- Core stalls its FSM on a not-done port.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request, port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  AW  byte address.
- wdata0, wdata1  in  DW  write data.
- done0, done1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DW  read data; valid while the matching done is high.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid on the last BUSY cycle.
- grant_id  out  1  requester currently owning the port.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (synchronous, checked before all else):
  - State goes to IDLE and the counter clears.
  - All outputs go to 0, including rdata0/1, mem_addr, mem_wdata and grant_id.
  - The last-grant pointer goes to 1, so port 0 wins the first tie.
- States:
  - IDLE: no request -> stay. Any req high -> arbitrate, register addr/we/wdata of the winner into mem_addr/mem_we-pending/mem_wdata, set grant_id, load cnt = MEM_LAT-1, go to BUSY.
  - BUSY: mem_en = 1 every cycle. mem_we = 1 only when cnt == 0 and the captured op is a write, so memory sees exactly one write strobe. cnt decrements each cycle. At cnt == 0, read data is captured from mem_rdata into the granted rdataX and the state goes to DONE.
  - DONE: doneX = 1 for the granted port only; mem_en = mem_we = 0. Always go to IDLE next (one bubble cycle), then update the last-grant pointer.
- Latency: req sampled high at edge 0 -> BUSY for cycles 1..MEM_LAT -> done in cycle MEM_LAT+1 -> IDLE in cycle MEM_LAT+2. Back-to-back accesses on one port therefore take MEM_LAT+2 cycles each.
- Handshake:
  - Requester holds req, we, addr and wdata stable until done.
  - Inputs are captured once at grant; later changes are ignored.
  - Dropping req mid-access does not cancel it; done still pulses.
  - req held high through done is treated as a new request in the following IDLE cycle.
- rdataX holds its last captured value until the next read completes on that port. Write accesses leave rdataX unchanged.
- Arbitration with the macro undefined: fixed priority, port 0 wins a simultaneous request.
- done0 and done1 are never high together; mem_we never asserts outside BUSY.
- Reset mid-access: the access is aborted, no done pulse is issued, and mem_en/mem_we are 0 from the next cycle.
- MEM_LAT = 1: cnt loads 0, BUSY lasts exactly one cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the port not granted last wins (the last-grant pointer updates on each DONE). A single requester always wins regardless of the pointer.
- Undefined: fixed priority to port 0; port 1 can starve under continuous port-0 traffic. The pointer register is still present but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10);
  - the requester ID constants (REQ_CORE = 0, REQ_DMA = 1);
  - the counter width constant (4 bits).
- Sub-module arb_pick is combinational: inputs req0, req1 and the last-grant pointer; outputs grant_valid and grant_id. It holds the macro-dependent priority logic so the FSM stays policy-free.

Test Plan:
- Single read, MEM_LAT=2: port 0 reads 0x0000_0010, memory returns 0xDEAD_BEEF -> mem_en high cycles 1–2, done0 and rdata0 = 0xDEAD_BEEF in cycle 3, done1 stays 0.
- Single write, port 1: addr 0x0000_0100, wdata 0x1234_5678 -> exactly one mem_we pulse in cycle 2 with that addr/data; done1 in cycle 3; rdata1 unchanged.
- Simultaneous requests, both held high for 4 accesses:
  - Fixed priority: grant order 0,0,0,0 and port 1 never done.
  - ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
- Reset asserted in cycle 1 of a port-0 write -> no mem_we, no done0, all outputs 0 next cycle; a subsequent port-1 read completes normally.
- MEM_LAT=1 back-to-back reads on port 0 with req held -> done0 in cycles 2, 5, 8 (period 3), each rdata0 matching the address presented.
- Port 0 changes addr after grant (0x40 -> 0x80) -> mem_addr stays 0x40 for the whole access.
